vga_timing_gen: RTL

Raster timing generator for the display path. It produces the pixel coordinates (`vga_x`, `vga_y`), the active-video qualifier (`vga_valid`), and the sync and frame markers. These feed `char_renderer` and the other overlay stages directly. Default timing is 1280x720@60 (74.25 MHz pixel rate), advanced by a pixel-enable strobe so the block can also run from a faster system clock.

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 74 +++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-enable strobe in, coordinates, qualifiers and sync out.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [10:0] vga_x;
  logic [9:0]  vga_y;
  logic        vga_valid;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    input  pix_en,
    output vga_x, vga_y, vga_valid, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  vga_x, vga_y, vga_valid, hsync, vsync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks (x, y) over the full frame on each pixel enable and
// registers every qualifier from the same position so downstream sees them aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        hs_window;
  logic        vs_window;
  logic        at_origin;

  always_comb begin
    h_next = vga.vga_x + 11'd1;
    v_next = vga.vga_y;
    if (vga.vga_x == H_LAST) begin
      h_next = '0;
      v_next = (vga.vga_y == V_LAST) ? '0 : vga.vga_y + 10'd1;
    end
    hs_window = (h_next >= HS_START) && (h_next < HS_END);
    vs_window = (v_next >= VS_START) && (v_next < VS_END);
    at_origin = (h_next == '0) && (v_next == '0);
  end

  // NOTE: qualifiers are decoded from the next position and registered alongside it,
  // so every output is a flop and lines up with vga_x/vga_y in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.vga_x       <= H_LAST;
      vga.vga_y       <= V_LAST;
      vga.vga_valid   <= 1'b0;
      vga.hsync       <= ~HS_POL;
      vga.vsync       <= ~VS_POL;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.frame_count <= 8'hFF;
    end else if (vga.pix_en) begin
      vga.vga_x       <= h_next;
      vga.vga_y       <= v_next;
      vga.vga_valid   <= (h_next < H_ACT) && (v_next < V_ACT);
      vga.hsync       <= hs_window ? HS_POL : ~HS_POL;
      vga.vsync       <= vs_window ? VS_POL : ~VS_POL;
      vga.line_start  <= (h_next == '0);
      vga.frame_start <= at_origin;
      if (at_origin) vga.frame_count <= vga.frame_count + 8'd1;
    end
  end

endmodule
